// File: rtl/mmio_timer_if.sv
// Data-memory bus bundle shared by the core's load/store unit and its responders.
// The master modport drives the request; the slave modport returns read data.
interface mmio_timer_if;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic [3:0]  mask;
    logic        rd_en;
    logic        wr_en;
    logic        cs;
    logic [31:0] read_data;

    modport master (
        output addr, write_data, mask, rd_en, wr_en, cs,
        input  read_data
    );

    modport slave (
        input  addr, write_data, mask, rd_en, wr_en, cs,
        output read_data
    );
endinterface

// File: rtl/mmio_timer.sv
// Memory-mapped prescaled 32-bit timer with compare match, sticky flag and level irq.
// Reads are combinational; writes and counting commit on the rising clock edge.
module mmio_timer #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
    parameter int          PRESC_W   = 16
) (
    input  logic         clk,
    input  logic         reset,
    mmio_timer_if.slave  bus,
    output logic         irq
);

    localparam logic [1:0] OFF_CTRL    = 2'd0;
    localparam logic [1:0] OFF_PRESC   = 2'd1;
    localparam logic [1:0] OFF_COUNT   = 2'd2;
    localparam logic [1:0] OFF_COMPARE = 2'd3;

    function automatic logic [31:0] merge_lanes(
        input logic [31:0] old_val,
        input logic [31:0] new_val,
        input logic [3:0]  lanes
    );
        logic [31:0] result;
        for (int i = 0; i < 4; i++) begin
            result[8*i +: 8] = lanes[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
        end
        return result;
    endfunction

    logic               en_q, auto_reload_q, irq_en_q, flag_q;
    logic [PRESC_W-1:0] presc_q, pcnt_q;
    logic [31:0]        count_q, compare_q;

    logic               en_d, auto_reload_d, irq_en_d, flag_d;
    logic [PRESC_W-1:0] presc_d, pcnt_d;
    logic [31:0]        count_d, compare_d;

    logic       hit, wr_hit;
    logic       wr_ctrl, wr_presc, wr_count, wr_compare;
    logic       tick, match, w1c;
    logic [1:0] sel;

    assign hit        = bus.cs && (bus.addr[31:4] == BASE_ADDR[31:4]);
    assign sel        = bus.addr[3:2];
    assign wr_hit     = hit && bus.wr_en;
    assign wr_ctrl    = wr_hit && (sel == OFF_CTRL);
    assign wr_presc   = wr_hit && (sel == OFF_PRESC);
    assign wr_count   = wr_hit && (sel == OFF_COUNT);
    assign wr_compare = wr_hit && (sel == OFF_COMPARE);

    // A PRESC write restarts the period, so it suppresses the tick of that cycle.
    assign tick  = en_q && !wr_presc && (pcnt_q == presc_q);
    assign match = (count_q == compare_q);
    assign w1c   = wr_ctrl && bus.mask[1] && bus.write_data[8];

    always_comb begin
        en_d          = en_q;
        auto_reload_d = auto_reload_q;
        irq_en_d      = irq_en_q;
        presc_d       = presc_q;
        pcnt_d        = pcnt_q;
        compare_d     = compare_q;
        count_d       = count_q;

        if (wr_presc) begin
            pcnt_d = '0;
        end else if (en_q) begin
            pcnt_d = (pcnt_q == presc_q) ? '0 : pcnt_q + PRESC_W'(1);
        end

        if (tick) begin
            count_d = (match && auto_reload_q) ? 32'd0 : count_q + 32'd1;
        end
        // Unwritten lanes of a COUNT store keep the tick result of this cycle.
        if (wr_count) begin
            count_d = merge_lanes(count_d, bus.write_data, bus.mask);
        end

        if (wr_compare) begin
            compare_d = merge_lanes(compare_q, bus.write_data, bus.mask);
        end

        if (wr_presc) begin
            for (int i = 0; i < PRESC_W; i++) begin
                if (bus.mask[i/8]) presc_d[i] = bus.write_data[i];
            end
        end

        if (wr_ctrl && bus.mask[0]) begin
            en_d          = bus.write_data[0];
            auto_reload_d = bus.write_data[1];
            irq_en_d      = bus.write_data[2];
        end

        flag_d = (flag_q && !w1c) || (tick && match);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            en_q          <= 1'b0;
            auto_reload_q <= 1'b0;
            irq_en_q      <= 1'b0;
            flag_q        <= 1'b0;
            presc_q       <= '0;
            pcnt_q        <= '0;
            count_q       <= 32'd0;
            compare_q     <= 32'hFFFF_FFFF;
        end else begin
            en_q          <= en_d;
            auto_reload_q <= auto_reload_d;
            irq_en_q      <= irq_en_d;
            flag_q        <= flag_d;
            presc_q       <= presc_d;
            pcnt_q        <= pcnt_d;
            count_q       <= count_d;
            compare_q     <= compare_d;
        end
    end

    always_comb begin
        bus.read_data = 32'd0;
        if (hit && bus.rd_en) begin
            case (sel)
                OFF_CTRL:    bus.read_data = {23'd0, flag_q, 5'd0, irq_en_q, auto_reload_q, en_q};
                OFF_PRESC:   bus.read_data[PRESC_W-1:0] = presc_q;
                OFF_COUNT:   bus.read_data = count_q;
                default:     bus.read_data = compare_q;
            endcase
        end
    end

    assign irq = flag_q && irq_en_q;

endmodule

// File: tb/tb_mmio_timer.sv
// Directed plus randomized bench for mmio_timer against a register-level reference model.
module tb_mmio_timer;

    localparam logic [31:0] BASE = 32'h0000_1000;

    logic clk = 1'b0;
    logic reset;
    logic irq;
    mmio_timer_if bus ();

    mmio_timer #(.BASE_ADDR(BASE), .PRESC_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    int   nchk = 0;
    int   nerr = 0;
    bit   started = 1'b0;
    logic last_irq;

    bit        m_en, m_ar, m_ie, m_flag;
    bit [15:0] m_presc, m_pcnt;
    bit [31:0] m_count, m_compare;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a, input bit c, input bit r);
        if (!(c && r && a[31:4] == BASE[31:4])) return 32'd0;
        case (a[3:2])
            2'd0:    return {23'd0, m_flag, 5'd0, m_ie, m_ar, m_en};
            2'd1:    return {16'd0, m_presc};
            2'd2:    return m_count;
            default: return m_compare;
        endcase
    endfunction

    task automatic model_step(input bit rst_i, input bit w, input logic [31:0] a,
                              input logic [31:0] d, input logic [3:0] m, input bit c);
        bit hitw, tick, set;
        if (rst_i) begin
            m_en = 0; m_ar = 0; m_ie = 0; m_flag = 0;
            m_presc = 0; m_pcnt = 0; m_count = 0; m_compare = 32'hFFFF_FFFF;
            return;
        end
        hitw = c && w && (a[31:4] == BASE[31:4]);
        tick = 0;
        set  = 0;
        if (hitw && a[3:2] == 2'd1) m_pcnt = 0;
        else if (m_en) begin
            if (m_pcnt == m_presc) begin tick = 1; m_pcnt = 0; end
            else m_pcnt = m_pcnt + 1;
        end
        if (tick) begin
            if (m_count == m_compare) begin
                set = 1;
                m_count = m_ar ? 32'd0 : m_count + 1;
            end else m_count = m_count + 1;
        end
        if (hitw) begin
            case (a[3:2])
                2'd0: begin
                    if (m[0]) begin m_en = d[0]; m_ar = d[1]; m_ie = d[2]; end
                    if (m[1] && d[8]) m_flag = 0;
                end
                2'd1: for (int i = 0; i < 2; i++) if (m[i]) m_presc[8*i +: 8] = d[8*i +: 8];
                2'd2: for (int i = 0; i < 4; i++) if (m[i]) m_count[8*i +: 8] = d[8*i +: 8];
                default: for (int i = 0; i < 4; i++) if (m[i]) m_compare[8*i +: 8] = d[8*i +: 8];
            endcase
        end
        if (set) m_flag = 1;
    endtask

    task automatic cyc(input bit rst_i, input bit w, input bit r, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] m, input bit c,
                       output logic [31:0] rd);
        @(negedge clk);
        reset          = rst_i;
        bus.cs         = c;
        bus.addr       = a;
        bus.write_data = d;
        bus.mask       = m;
        bus.wr_en      = w;
        bus.rd_en      = r;
        #1;
        rd       = bus.read_data;
        last_irq = irq;
        chk("read_data", rd, model_read(a, c, r));
        if (started) chk("irq", {31'd0, irq}, {31'd0, m_flag & m_ie});
        @(posedge clk);
        model_step(rst_i, w, a, d, m, c);
        if (rst_i) started = 1'b1;
    endtask

    task automatic wr(input logic [1:0] off, input logic [31:0] d, input logic [3:0] m);
        logic [31:0] rd;
        cyc(0, 1, 0, BASE | {28'd0, off, 2'b00}, d, m, 1, rd);
    endtask

    task automatic rdv(input logic [1:0] off, input logic [31:0] exp, input string tag);
        logic [31:0] rd;
        cyc(0, 0, 1, BASE | {28'd0, off, 2'b00}, 32'd0, 4'd0, 1, rd);
        chk(tag, rd, exp);
    endtask

    task automatic idle();
        logic [31:0] rd;
        cyc(0, 0, 0, 32'd0, 32'd0, 4'd0, 0, rd);
    endtask

    initial begin
        logic [31:0] rd, a, d;
        logic [3:0]  m;
        bit          w, r, c, rs;

        reset = 1'b1;
        bus.cs = 0; bus.addr = 0; bus.write_data = 0; bus.mask = 0;
        bus.wr_en = 0; bus.rd_en = 0;

        // Reset values and out-of-window read
        cyc(1, 0, 0, 32'd0, 32'd0, 4'd0, 0, rd);
        rdv(2'd0, 32'd0, "rst_ctrl");
        rdv(2'd1, 32'd0, "rst_presc");
        rdv(2'd2, 32'd0, "rst_count");
        rdv(2'd3, 32'hFFFF_FFFF, "rst_compare");
        cyc(0, 0, 1, BASE + 32'h10, 32'd0, 4'd0, 1, rd);
        chk("miss_read", rd, 32'd0);
        chk("rst_irq", {31'd0, last_irq}, 32'd0);

        // PRESC=3, COMPARE=2, auto-reload: 0,1,2,0 with four cycles per step
        wr(2'd1, 32'd3, 4'hF);
        wr(2'd3, 32'd2, 4'hF);
        wr(2'd0, 32'h7, 4'hF);
        for (int k = 1; k <= 13; k++) begin
            cyc(0, 0, 1, BASE + 32'h8, 32'd0, 4'd0, 1, rd);
            chk("ps3_count", rd, (k <= 4) ? 32'd0 : (k <= 8) ? 32'd1 : (k <= 12) ? 32'd2 : 32'd0);
        end
        chk("match_irq", {31'd0, last_irq}, 32'd1);
        wr(2'd0, 32'h100, 4'b0010);
        idle();
        chk("w1c_irq", {31'd0, last_irq}, 32'd0);
        wr(2'd0, 32'd0, 4'b0001);

        // Byte-masked COMPARE store
        wr(2'd3, 32'hFFFF_FFFF, 4'hF);
        wr(2'd3, 32'hAABB_CCDD, 4'b0101);
        rdv(2'd3, 32'hFFBB_FFDD, "mask_compare");

        // Wrap without auto-reload, flag only at COUNT==COMPARE
        wr(2'd1, 32'd0, 4'hF);
        wr(2'd2, 32'hFFFF_FFFE, 4'hF);
        wr(2'd3, 32'd5, 4'hF);
        wr(2'd0, 32'h5, 4'b0001);
        for (int k = 1; k <= 10; k++) begin
            cyc(0, 0, 1, BASE + 32'h8, 32'd0, 4'd0, 1, rd);
            chk("wrap_count", rd, 32'hFFFF_FFFE + 32'(k - 1));
            chk("wrap_irq", {31'd0, last_irq}, (k >= 9) ? 32'd1 : 32'd0);
        end

        // Collisions: COUNT write on a tick edge, W1C on a match edge
        wr(2'd0, 32'h105, 4'b0011);
        wr(2'd2, 32'h10, 4'hF);
        rdv(2'd2, 32'h10, "col_count");
        wr(2'd3, 32'h20, 4'hF);
        wr(2'd2, 32'h1E, 4'hF);
        idle();
        idle();
        wr(2'd0, 32'h100, 4'b0010);
        rdv(2'd0, 32'h105, "col_w1c");

        // Reset mid-period with flag set; same-cycle write is discarded
        wr(2'd1, 32'd3, 4'hF);
        idle();
        idle();
        cyc(1, 1, 0, BASE + 32'hC, 32'd7, 4'hF, 1, rd);
        rdv(2'd0, 32'd0, "rst2_ctrl");
        chk("rst2_irq", {31'd0, last_irq}, 32'd0);
        rdv(2'd1, 32'd0, "rst2_presc");
        rdv(2'd2, 32'd0, "rst2_count");
        rdv(2'd3, 32'hFFFF_FFFF, "rst2_compare");
        for (int k = 0; k < 5; k++) idle();
        rdv(2'd2, 32'd0, "rst2_stopped");

        // Randomized traffic against the reference model
        for (int n = 0; n < 2000; n++) begin
            rs = ($urandom_range(0, 299) == 0);
            c  = ($urandom_range(0, 9) != 0);
            w  = ($urandom_range(0, 2) == 0);
            r  = ($urandom_range(0, 1) == 1);
            m  = 4'($urandom_range(0, 15));
            a  = BASE | 32'($urandom_range(0, 15));
            if ($urandom_range(0, 15) == 0) a = $urandom;
            case (a[3:2])
                2'd0:    d = ($urandom & 32'hFFFF_FE00) | 32'($urandom_range(0, 511));
                2'd1:    d = ($urandom & 32'hFFFF_0000) | 32'($urandom_range(0, 3));
                default: d = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 24));
            endcase
            cyc(rs, w, r, a, d, m, c, rd);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
